uart_rcv: RTL and testbench



---
 rtl/uart_rcv.sv | 154 +++++++++++++++
 tb/tb_uart_rcv.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rcv.sv
// uart_rcv: 8N1 UART receiver feeding the Segway authentication block.
// The serial line is double-synchronized, each frame is sampled at
// mid-bit, and every completed byte is presented on rx_data with a
// sticky rdy flag.
//
// Optional build macro: UART_RCV_FRAME_CHK_EN.
//   Defined   : frm_err reports a bad (zero) stop bit, and such frames
//               update rx_data without setting rdy.
//   Undefined : frm_err is tied low, and every completed frame sets rdy.
//
// Handshake: rdy is a sticky "byte available" level. It rises one clock
// after the mid-stop-bit sample. It falls on the clock after clr_rdy is
// high, or when a new start edge is accepted. When completion and a clear
// land on the same clock, completion wins.
module uart_rcv #(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  localparam logic [15:0] HALF_DIV    = 16'(BAUD_DIV / 2);
  localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RCV  = 1'b1
  } state_t;

  state_t      state;
  state_t      nxt_state;

  logic        rx_meta;
  logic        rx_s;
  logic        rx_q;
  logic [15:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [8:0]  shift;
  logic        cmplt;

  logic        fall;
  logic        start;
  logic        sample;
  logic        false_start;
  logic        last_sample;
  logic        set_rdy;

  // Two-flop synchronizer plus one delay flop for falling-edge detection;
  // all three reset high so the line reads idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

  assign fall        = rx_q & ~rx_s;
  assign sample      = (state == RCV) && (baud_cnt == 16'd0);
  assign false_start = sample && (bit_cnt == 4'd0) && rx_s;
  assign last_sample = sample && (bit_cnt == 4'd9);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  // Next-state logic: IDLE waits for a start edge; RCV leaves on a false
  // start or straight after the stop-bit sample, so a following start edge
  // half a bit later is seen with no dead time.
  always_comb begin
    nxt_state = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          nxt_state = RCV;
          start     = 1'b1;
        end
      end
      RCV: begin
        if (false_start || last_sample) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Baud and bit counters plus the shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= 16'd0;
      bit_cnt  <= 4'd0;
      shift    <= 9'd0;
    end else if (start) begin
      baud_cnt <= HALF_DIV;
      bit_cnt  <= 4'd0;
    end else if (state == RCV) begin
      if (baud_cnt == 16'd0) begin
        baud_cnt <= BAUD_RELOAD;
        if (!false_start) begin
          shift   <= {rx_s, shift[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt - 16'd1;
      end
    end
  end

  // Completion strobe: one clock after the stop-bit sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmplt <= 1'b0;
    else        cmplt <= last_sample;
  end

`ifdef UART_RCV_FRAME_CHK_EN
  assign set_rdy = cmplt & shift[8];

  // Frame error tracks the stop bit of the most recent completed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     frm_err <= 1'b0;
    else if (cmplt) frm_err <= ~shift[8];
  end
`else
  logic unused_stop;
  assign unused_stop = shift[8];
  assign set_rdy     = cmplt;
  assign frm_err     = 1'b0;
`endif

  // Output byte and sticky ready flag; completion takes priority over
  // both clear sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= 8'h00;
      rdy     <= 1'b0;
    end else begin
      if (cmplt) rx_data <= shift[7:0];
      if (set_rdy)               rdy <= 1'b1;
      else if (clr_rdy || start) rdy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rcv.sv
// tb_uart_rcv: directed bench for uart_rcv at BAUD_DIV=16. Drivers post
// the frame timing they create into an event model; a compare process
// checks rdy/rx_data/frm_err against that model every clock.
`timescale 1ns/1ps
module tb_uart_rcv;

  localparam int BAUD     = 16;
  localparam int HALF     = BAUD / 2;
  // Start edge driven just after clock n: rdy clears after clock n+CLR_OFF,
  // the byte lands after clock n+DONE_OFF (two sync flops, edge detect,
  // HALF+1 clocks to mid-start, nine more bit periods, one output clock).
  localparam int CLR_OFF  = 3;
  localparam int DONE_OFF = 5 + HALF + 9 * BAUD;
  localparam int MAXC     = 8192;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       rx      = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;

  uart_rcv #(.BAUD_DIV(BAUD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (rx),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model state ----------------
  int         cyc   = 0;
  int         n_vec = 0;
  int         n_err = 0;
  int         n0;
  bit         ev_clr  [MAXC];
  bit         ev_set  [MAXC];
  bit         ev_stop [MAXC];
  logic [7:0] exp_q[$];
  logic       exp_rdy  = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic       exp_err  = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    exp_rdy  = 1'b0;
    exp_data = 8'h00;
    exp_err  = 1'b0;
    exp_q.delete();
    for (int i = cyc + 1; i < MAXC; i++) begin
      ev_clr[i]  = 1'b0;
      ev_set[i]  = 1'b0;
      ev_stop[i] = 1'b0;
    end
  endtask

  // Compare process: apply this clock's events to the model, then compare.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (ev_clr[cyc]) exp_rdy = 1'b0;
      if (ev_set[cyc]) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL model_queue: empty at completion, cycle %0d", cyc);
        end else begin
          exp_data = exp_q.pop_front();
        end
`ifdef UART_RCV_FRAME_CHK_EN
        exp_err = ~ev_stop[cyc];
        if (ev_stop[cyc]) exp_rdy = 1'b1;
`else
        exp_rdy = 1'b1;
`endif
      end
      n_vec++;
      if (rdy !== exp_rdy || rx_data !== exp_data || frm_err !== exp_err) begin
        n_err++;
        $display("FAIL cycle_compare cyc=%0d: got rdy=%b data=%h err=%b, required rdy=%b data=%h err=%b",
                 cyc, rdy, rx_data, frm_err, exp_rdy, exp_data, exp_err);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Sends one frame LSB first; tail_low holds the line low for extra bit
  // times after the stop bit; cut_at > 0 stops driving after that many clocks.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int tail_low, input int cut_at);
    int         n;
    logic [9:0] bits;
    n    = cyc;
    bits = {stop, d, 1'b0};
    ev_clr[n + CLR_OFF]   = 1'b1;
    ev_set[n + DONE_OFF]  = 1'b1;
    ev_stop[n + DONE_OFF] = stop;
    exp_q.push_back(d);
    for (int c = 0; c < 10 * BAUD; c++) begin
      if (cut_at != 0 && c == cut_at) return;
      rx = bits[c / BAUD];
      tick();
    end
    if (tail_low > 0) begin
      rx = 1'b0;
      idle(tail_low * BAUD);
    end
    rx = 1'b1;
  endtask

  task automatic send_glitch(input int len);
    ev_clr[cyc + CLR_OFF] = 1'b1;
    rx = 1'b0;
    idle(len);
    rx = 1'b1;
  endtask

  task automatic pulse_clr_at(input int target);
    repeat (target - 1 - cyc) tick();
    clr_rdy = 1'b1;
    ev_clr[target] = 1'b1;
    tick();
    clr_rdy = 1'b0;
  endtask

  task automatic check_first_latency(input int n);
    repeat (n + DONE_OFF - 1 - cyc) tick();
    check("rdy_before_done", {7'd0, rdy}, 8'h00);
    tick();
    check("rdy_at_done", {7'd0, rdy}, 8'h01);
    check("data_at_done", rx_data, 8'h47);
  endtask

  task automatic reset_mid_frame();
    #1;
    rst_n   = 1'b0;
    rx      = 1'b1;
    clr_rdy = 1'b0;
    model_reset();
    #1;
    check("rst_mid_rdy", {7'd0, rdy}, 8'h00);
    check("rst_mid_data", rx_data, 8'h00);
    check("rst_mid_err", {7'd0, frm_err}, 8'h00);
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("reset_rdy", {7'd0, rdy}, 8'h00);
    check("reset_data", rx_data, 8'h00);
    check("reset_err", {7'd0, frm_err}, 8'h00);
    rst_n = 1'b1;
    idle(5);

    // 'G' and its latency
    n0 = cyc;
    fork
      send_frame(8'h47, 1'b1, 0, 0);
      check_first_latency(n0);
    join
    check("g_err", {7'd0, frm_err}, 8'h00);
    idle(10);
    pulse_clr_at(cyc + 1);
    check("clr_rdy", {7'd0, rdy}, 8'h00);
    check("clr_keeps_data", rx_data, 8'h47);

    // 'S' with clr_rdy on the exact completion clock
    n0 = cyc;
    fork
      send_frame(8'h53, 1'b1, 0, 0);
      pulse_clr_at(n0 + DONE_OFF);
    join
    check("set_beats_clr_rdy", {7'd0, rdy}, 8'h01);
    check("set_beats_clr_data", rx_data, 8'h53);
    pulse_clr_at(cyc + 1);
    idle(5);
    pulse_clr_at(cyc + 1);
    check("clr_when_empty", {7'd0, rdy}, 8'h00);

    // false start, then a clean frame
    send_glitch(3);
    idle(40);
    check("glitch_rdy", {7'd0, rdy}, 8'h00);
    check("glitch_data", rx_data, 8'h53);
    send_frame(8'hA5, 1'b1, 0, 0);
    check("a5_rdy", {7'd0, rdy}, 8'h01);
    check("a5_data", rx_data, 8'hA5);
    idle(10);

    // back-to-back, no clr
    send_frame(8'h00, 1'b1, 0, 0);
    send_frame(8'hFF, 1'b1, 0, 0);
    check("b2b_rdy", {7'd0, rdy}, 8'h01);
    check("b2b_data", rx_data, 8'hFF);
    pulse_clr_at(cyc + 1);
    idle(5);

    // bad stop bit followed by a two-bit break
    send_frame(8'h55, 1'b0, 2, 0);
    idle(20);
    check("bad_stop_data", rx_data, 8'h55);
`ifdef UART_RCV_FRAME_CHK_EN
    check("bad_stop_rdy", {7'd0, rdy}, 8'h00);
    check("bad_stop_err", {7'd0, frm_err}, 8'h01);
`else
    check("bad_stop_rdy", {7'd0, rdy}, 8'h01);
    check("bad_stop_err", {7'd0, frm_err}, 8'h00);
`endif
    idle(5);

    // reset in the middle of data bit 4, then a full frame
    send_frame(8'h3C, 1'b1, 0, 5 * BAUD + HALF);
    reset_mid_frame();
    idle(5);
    send_frame(8'hC3, 1'b1, 0, 0);
    check("after_rst_rdy", {7'd0, rdy}, 8'h01);
    check("after_rst_data", rx_data, 8'hC3);
    check("after_rst_err", {7'd0, frm_err}, 8'h00);
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
